id_ex_skid_reg: RTL and testbench

- Parametrised successor of the ID→EX pipeline register.
- Replaces the single freeze-gated register with a valid/ready handshake and a 2-entry skid buffer (output register plus skid register). ID can therefore be back-pressured without a combinational ready path from EX.
- Keeps global freeze and flush, with a stronger rule: flush is always honoured, even under freeze.
- Sits between the ID stage and the EX stage / forwarding unit.

---
 rtl/id_ex_pkg.sv | 41 ++++
 rtl/skid_buffer2.sv | 67 ++++++
 rtl/id_ex_skid_reg.sv | 114 +++++++++++
 tb/tb_id_ex_skid_reg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared types for the ID->EX skid register: payload layout, occupancy states,
// and a saturating adder for the optional statistics counters.
package id_ex_pkg;

   localparam int unsigned ID_EX_DATA_W     = 32;
   localparam int unsigned ID_EX_PC_W       = 32;
   localparam int unsigned ID_EX_REG_ADDR_W = 5;
   localparam int unsigned ID_EX_EXCMD_W    = 4;
   localparam int unsigned ID_EX_BR_W       = 2;

   typedef struct packed {
      logic [ID_EX_PC_W-1:0]       pc;
      logic                        wb_en;
      logic                        mem_write;
      logic                        mem_read;
      logic                        is_two_source;
      logic [ID_EX_EXCMD_W-1:0]    ex_cmd;
      logic [ID_EX_BR_W-1:0]       branch_type;
      logic [ID_EX_DATA_W-1:0]     val1;
      logic [ID_EX_DATA_W-1:0]     val2;
      logic [ID_EX_DATA_W-1:0]     reg2;
      logic [ID_EX_REG_ADDR_W-1:0] dst;
      logic [ID_EX_REG_ADDR_W-1:0] src1;
      logic [ID_EX_REG_ADDR_W-1:0] src2;
   } id_ex_payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_t;

   localparam id_ex_payload_t ID_EX_PAYLOAD_ZERO = '0;

   function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {31'd0, b};
      return sum[32] ? '1 : sum[31:0];
   endfunction

endpackage

// File: rtl/skid_buffer2.sv
// Generic 2-entry valid/ready buffer (output register + skid register) with
// flush (always honoured) and freeze (holds everything). in_ready is registered.
module skid_buffer2
   import id_ex_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         freeze,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output skid_state_t  state
);

   logic [W-1:0] skid_q;
   logic         out_valid;
   logic         in_fire;
   logic         out_fire;
   skid_state_t  state_n;

   assign out_valid = (state != EMPTY);
   assign in_fire   = in_valid & in_ready & ~freeze & ~flush;
   assign out_fire  = out_valid & out_ready & ~freeze & ~flush;

   always_comb begin
      state_n = state;
      case (state)
         EMPTY:   if (in_fire) state_n = ONE;
         ONE: begin
            if (in_fire && !out_fire)      state_n = TWO;
            else if (!in_fire && out_fire) state_n = EMPTY;
         end
         TWO:     if (out_fire) state_n = ONE;
         default: state_n = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= EMPTY;
         out_data <= '0;
         skid_q   <= '0;
         in_ready <= 1'b0;
      end else if (flush) begin
         state    <= EMPTY;
         out_data <= '0;
         skid_q   <= '0;
         in_ready <= ~freeze;
      end else begin
         state    <= state_n;
         in_ready <= (state_n != TWO) & ~freeze;
         // Skid drains before any newer word can reach the output register.
         if (state == TWO) begin
            if (out_fire) out_data <= skid_q;
         end else if (in_fire) begin
            if (state == EMPTY || out_fire) out_data <= in_data;
            else                            skid_q   <= in_data;
         end
      end
   end

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID->EX pipeline register with valid/ready handshake and 2-entry skid buffer.
// Define ID_EX_SKID_STATS_EN to add saturating stall/flush-kill/issue counters.
module id_ex_skid_reg
   import id_ex_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned PC_W       = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned EXCMD_W    = 4,
   parameter int unsigned BR_W       = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  freeze,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [PC_W-1:0]       in_pc,
   input  logic                  in_wb_en,
   input  logic                  in_mem_write,
   input  logic                  in_mem_read,
   input  logic                  in_is_two_source,
   input  logic [EXCMD_W-1:0]    in_ex_cmd,
   input  logic [BR_W-1:0]       in_branch_type,
   input  logic [DATA_W-1:0]     in_val1,
   input  logic [DATA_W-1:0]     in_val2,
   input  logic [DATA_W-1:0]     in_reg2,
   input  logic [REG_ADDR_W-1:0] in_dst,
   input  logic [REG_ADDR_W-1:0] in_src1,
   input  logic [REG_ADDR_W-1:0] in_src2,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PC_W-1:0]       out_pc,
   output logic                  out_wb_en,
   output logic                  out_mem_write,
   output logic                  out_mem_read,
   output logic                  out_is_two_source,
   output logic [EXCMD_W-1:0]    out_ex_cmd,
   output logic [BR_W-1:0]       out_branch_type,
   output logic [DATA_W-1:0]     out_val1,
   output logic [DATA_W-1:0]     out_val2,
   output logic [DATA_W-1:0]     out_reg2,
   output logic [REG_ADDR_W-1:0] out_dst,
   output logic [REG_ADDR_W-1:0] out_src1,
   output logic [REG_ADDR_W-1:0] out_src2
`ifdef ID_EX_SKID_STATS_EN
   ,
   output logic [31:0]           stat_stall_cycles,
   output logic [31:0]           stat_flush_kills,
   output logic [31:0]           stat_issued
`endif
);

   localparam int unsigned W = PC_W + 4 + EXCMD_W + BR_W + 3*DATA_W + 3*REG_ADDR_W;

   logic [W-1:0] in_data;
   logic [W-1:0] out_data;
   skid_state_t  state;
   logic         wb_en_q;
   logic         mem_write_q;
   logic         mem_read_q;
   logic         two_src_q;
   logic [BR_W-1:0] br_q;

   assign in_data = {in_pc, in_wb_en, in_mem_write, in_mem_read, in_is_two_source,
                     in_ex_cmd, in_branch_type, in_val1, in_val2, in_reg2,
                     in_dst, in_src1, in_src2};

   skid_buffer2 #(.W(W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .freeze    (freeze),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_ready (out_ready),
      .out_data  (out_data),
      .state     (state)
   );

   assign {out_pc, wb_en_q, mem_write_q, mem_read_q, two_src_q,
           out_ex_cmd, br_q, out_val1, out_val2, out_reg2,
           out_dst, out_src1, out_src2} = out_data;

   // Control bits are gated so a bubble can never write back or touch memory.
   assign out_valid         = (state != EMPTY);
   assign out_wb_en         = wb_en_q & out_valid;
   assign out_mem_write     = mem_write_q & out_valid;
   assign out_mem_read      = mem_read_q & out_valid;
   assign out_is_two_source = two_src_q & out_valid;
   assign out_branch_type   = br_q & {BR_W{out_valid}};

`ifdef ID_EX_SKID_STATS_EN
   logic [1:0] held;
   logic       out_fire;

   assign held     = (state == TWO) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
   assign out_fire = out_valid & out_ready & ~freeze & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_stall_cycles <= '0;
         stat_flush_kills  <= '0;
         stat_issued       <= '0;
      end else begin
         if (in_valid && !in_ready) stat_stall_cycles <= sat_add32(stat_stall_cycles, 2'd1);
         if (flush)                 stat_flush_kills  <= sat_add32(stat_flush_kills, held);
         if (out_fire)              stat_issued       <= sat_add32(stat_issued, 2'd1);
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed bench for id_ex_skid_reg: reset, streaming, back-pressure, freeze,
// flush-under-freeze, bubble gating and simultaneous fire in ONE.
module tb_id_ex_skid_reg;

   logic        clk = 1'b0;
   logic        rst, freeze, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_pc, out_pc, in_val1, in_val2, in_reg2, out_val1, out_val2, out_reg2;
   logic        in_wb_en, in_mem_write, in_mem_read, in_is_two_source;
   logic        out_wb_en, out_mem_write, out_mem_read, out_is_two_source;
   logic [3:0]  in_ex_cmd, out_ex_cmd;
   logic [1:0]  in_branch_type, out_branch_type;
   logic [4:0]  in_dst, in_src1, in_src2, out_dst, out_src1, out_src2;
`ifdef ID_EX_SKID_STATS_EN
   logic [31:0] stat_stall_cycles, stat_flush_kills, stat_issued;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_skid_reg #(.DATA_W(32), .PC_W(32), .REG_ADDR_W(5), .EXCMD_W(4), .BR_W(2)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_wb_en(in_wb_en), .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
      .in_is_two_source(in_is_two_source), .in_ex_cmd(in_ex_cmd),
      .in_branch_type(in_branch_type), .in_val1(in_val1), .in_val2(in_val2),
      .in_reg2(in_reg2), .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_wb_en(out_wb_en), .out_mem_write(out_mem_write), .out_mem_read(out_mem_read),
      .out_is_two_source(out_is_two_source), .out_ex_cmd(out_ex_cmd),
      .out_branch_type(out_branch_type), .out_val1(out_val1), .out_val2(out_val2),
      .out_reg2(out_reg2), .out_dst(out_dst), .out_src1(out_src1), .out_src2(out_src2)
`ifdef ID_EX_SKID_STATS_EN
      ,
      .stat_stall_cycles(stat_stall_cycles), .stat_flush_kills(stat_flush_kills),
      .stat_issued(stat_issued)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every instruction carries wb_en=1, mem_write=1, branch_type=2, dst=7;
   // val1 is derived from pc so payload integrity can be spot-checked.
   task automatic drive(input logic v, input logic [31:0] pc);
      in_valid         = v;
      in_pc            = pc;
      in_wb_en         = 1'b1;
      in_mem_write     = 1'b1;
      in_mem_read      = 1'b0;
      in_is_two_source = 1'b1;
      in_ex_cmd        = 4'h9;
      in_branch_type   = 2'b10;
      in_val1          = pc + 32'h1000;
      in_val2          = 32'hCAFE0000;
      in_reg2          = 32'h00001234;
      in_dst           = 5'd7;
      in_src1          = 5'd3;
      in_src2          = 5'd4;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0);

      // Reset
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_pc", out_pc, 0);
      step();
      rst = 1'b0;
      step();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      // Stream with 1-cycle lag
      out_ready = 1'b1;
      drive(1'b1, 32'h100);
      step();
      chk("flow_valid_100", out_valid, 1);
      chk("flow_pc_100", out_pc, 32'h100);
      chk("flow_val1_100", out_val1, 32'h1100);
      drive(1'b1, 32'h104);
      step();
      chk("flow_pc_104", out_pc, 32'h104);
      drive(1'b1, 32'h108);
      step();
      chk("flow_pc_108", out_pc, 32'h108);
      chk("flow_in_ready", in_ready, 1);

      // Drain to EMPTY: control bits gated, data fields hold
      drive(1'b0, 32'h0);
      step();
      chk("bubble_valid", out_valid, 0);
      chk("bubble_wb_en", out_wb_en, 0);
      chk("bubble_mem_write", out_mem_write, 0);
      chk("bubble_br", out_branch_type, 0);
      chk("bubble_dst_hold", out_dst, 7);
      chk("bubble_pc_hold", out_pc, 32'h108);

      // Back-pressure into TWO
      out_ready = 1'b0;
      drive(1'b1, 32'h200);
      step();
      chk("bp_pc_200", out_pc, 32'h200);
      chk("bp_ready_one", in_ready, 1);
      drive(1'b1, 32'h204);
      step();
      chk("bp_two_ready", in_ready, 0);
      chk("bp_two_pc", out_pc, 32'h200);
      chk("bp_two_wb", out_wb_en, 1);
      drive(1'b0, 32'h0);

      // Freeze in TWO with EX ready
      out_ready = 1'b1;
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("frz_pc", out_pc, 32'h200);
         chk("frz_valid", out_valid, 1);
      end
      freeze = 1'b0;
      step();
      chk("drain_pc_204", out_pc, 32'h204);
      chk("drain_in_ready", in_ready, 1);
      chk("drain_val1_204", out_val1, 32'h1204);
      step();
      chk("drain_empty", out_valid, 0);

      // Flush under freeze from TWO
      out_ready = 1'b0;
      drive(1'b1, 32'h400);
      step();
      drive(1'b1, 32'h404);
      step();
      chk("fl_setup_two", in_ready, 0);
      drive(1'b0, 32'h0);
      freeze = 1'b1;
      flush = 1'b1;
      step();
      chk("fl_valid", out_valid, 0);
      chk("fl_pc_zero", out_pc, 0);
      chk("fl_val1_zero", out_val1, 0);
      chk("fl_dst_zero", out_dst, 0);
      chk("fl_in_ready_frozen", in_ready, 0);
`ifdef ID_EX_SKID_STATS_EN
      chk("stat_flush_kills", stat_flush_kills, 2);
`endif
      flush = 1'b0;
      freeze = 1'b0;
      step();
      chk("fl_in_ready_back", in_ready, 1);
      chk("fl_still_empty", out_valid, 0);

      // Flush beats a simultaneous in_fire
      drive(1'b1, 32'h500);
      step();
      chk("fl2_pc_500", out_pc, 32'h500);
      drive(1'b1, 32'h504);
      flush = 1'b1;
      step();
      chk("fl2_valid", out_valid, 0);
      chk("fl2_pc_zero", out_pc, 0);
      chk("fl2_in_ready", in_ready, 1);
      flush = 1'b0;

      // Simultaneous in/out fire stays in ONE
      out_ready = 1'b1;
      drive(1'b1, 32'h300);
      step();
      chk("sim_pc_300", out_pc, 32'h300);
      drive(1'b1, 32'h304);
      step();
      chk("sim_pc_304", out_pc, 32'h304);
      chk("sim_in_ready", in_ready, 1);
      drive(1'b0, 32'h0);
      step();
      chk("sim_no_skid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
